// File: rtl/fir_bridge_pkg.sv
// Shared constants and payload types for the Wishbone-to-stream FIR bridge.
package fir_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [31:0] DEFAULT_BASE = 32'h3000_0080;

    // Byte offsets inside the 32-byte register window
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LEN    = 5'h04;
    localparam logic [4:0] OFF_X      = 5'h08;
    localparam logic [4:0] OFF_Y      = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [4:0] OFF_CNT    = 5'h14;

    // STATUS register bit positions
    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_RX_EMPTY = 1;
    localparam int unsigned ST_DONE     = 2;
    localparam int unsigned ST_TX_CNT   = 8;
    localparam int unsigned ST_RX_CNT   = 16;

    // One TX FIFO entry: sample plus its end-of-frame marker
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } tx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra MSB so full/empty are unambiguous.
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~clear & ~empty;
    assign do_push = push & ~clear & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; clear empties the FIFO without touching storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

endmodule

// File: rtl/fir_stream_bridge.sv
// Wishbone slave that feeds the FIR input stream from a TX FIFO and collects
// the FIR output stream into an RX FIFO, with frame tlast generation.
module fir_stream_bridge
    import fir_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] BASE  = DEFAULT_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        x_tvalid,
    input  logic        x_tready,
    output logic [31:0] x_tdata,
    output logic        x_tlast,
    input  logic        y_tvalid,
    output logic        y_tready,
    input  logic [31:0] y_tdata,
    input  logic        y_tlast
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [4:0]        off;
    logic              hit, req, acc, x_wr, y_rd, clear;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    tx_entry_t         tx_din, tx_head;
    logic [DATA_W-1:0] rx_head;
    logic [LEN_W-1:0]  len, frame_idx;
    logic [CNT_W-1:0]  sent, recv;
    logic              done, push_last;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // Request decode and hold-off for full TX / empty RX
    assign off   = {wbs_adr_i[4:2], 2'b00};
    assign hit   = (wbs_adr_i[31:5] == BASE[31:5]);
    assign req   = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign x_wr  = wbs_we_i & (off == OFF_X);
    assign y_rd  = ~wbs_we_i & (off == OFF_Y);
    assign acc   = req & ~(x_wr & tx_full) & ~(y_rd & rx_empty);
    assign clear = acc & wbs_we_i & (off == OFF_CTRL) & wbs_dat_i[0];

    // Stream handshakes; the FIFOs drop them when clear is active
    assign tx_push   = acc & x_wr;
    assign tx_pop    = x_tvalid & x_tready;
    assign rx_push   = y_tvalid & y_tready;
    assign rx_pop    = acc & y_rd;
    assign push_last = (len != '0) && (frame_idx == len - LEN_W'(1));
    assign tx_din    = '{last: push_last, data: wbs_dat_i};

    assign x_tvalid = ~tx_empty;
    assign x_tdata  = tx_empty ? '0 : tx_head.data;
    assign x_tlast  = ~tx_empty & tx_head.last;
    assign y_tready = ~rx_full;

    sync_fifo #(.DATA_W($bits(tx_entry_t)), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .clear (clear),
        .din   (tx_din),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .clear (clear),
        .din   (y_tdata),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Read data mux
    always_comb begin
        rdata = '0;
        case (off)
            OFF_LEN:    rdata = 32'(len);
            OFF_Y:      rdata = rx_head;
            OFF_STATUS: begin
                rdata[ST_TX_FULL]              = tx_full;
                rdata[ST_RX_EMPTY]             = rx_empty;
                rdata[ST_DONE]                 = done;
                rdata[ST_TX_CNT +: 8]          = 8'(tx_count);
                rdata[ST_RX_CNT +: 8]          = 8'(rx_count);
            end
            OFF_CNT:    rdata = {recv, sent};
            default:    rdata = '0;
        endcase
    end

    // Registered Wishbone acknowledge and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
        end
    end

    // Frame length register, survives CLEAR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len <= '0;
        end else if (acc & wbs_we_i & (off == OFF_LEN)) begin
            len <= wbs_dat_i[LEN_W-1:0];
        end
    end

    // Frame index, sample counters and sticky DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_idx <= '0;
            sent      <= '0;
            recv      <= '0;
            done      <= 1'b0;
        end else if (clear) begin
            frame_idx <= '0;
            sent      <= '0;
            recv      <= '0;
            done      <= 1'b0;
        end else begin
            if (tx_push) frame_idx <= push_last ? '0 : frame_idx + LEN_W'(1);
            if (tx_pop)  sent <= sent + CNT_W'(1);
            if (rx_push) begin
                recv <= recv + CNT_W'(1);
                if (y_tlast) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_bridge.sv
// Directed self-checking bench for fir_stream_bridge.
module tb_fir_stream_bridge;

    localparam logic [31:0] A_CTRL   = 32'h3000_0080;
    localparam logic [31:0] A_LEN    = 32'h3000_0084;
    localparam logic [31:0] A_X      = 32'h3000_0088;
    localparam logic [31:0] A_Y      = 32'h3000_008C;
    localparam logic [31:0] A_STATUS = 32'h3000_0090;
    localparam logic [31:0] A_CNT    = 32'h3000_0094;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        x_tvalid, x_tlast;
    logic        x_tready = 1'b0;
    logic [31:0] x_tdata;
    logic        y_tvalid = 1'b0, y_tlast = 1'b0;
    logic        y_tready;
    logic [31:0] y_tdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    fir_stream_bridge #(.DEPTH(8), .BASE(32'h3000_0080)) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .x_tvalid  (x_tvalid),
        .x_tready  (x_tready),
        .x_tdata   (x_tdata),
        .x_tlast   (x_tlast),
        .y_tvalid  (y_tvalid),
        .y_tready  (y_tready),
        .y_tdata   (y_tdata),
        .y_tlast   (y_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit ok);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        ok = 1'b0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack) begin
                ok = 1'b1;
                rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bit ok;
        wb(1'b1, a, d, rd, ok);
        check({name, "_ack"}, 32'(ok), 32'd1);
    endtask

    task automatic wb_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bit ok;
        wb(1'b0, a, '0, rd, ok);
        check({name, "_ack"}, 32'(ok), 32'd1);
        check(name, rd, exp);
    endtask

    task automatic y_push(input logic [31:0] d, input logic last);
        y_tvalid = 1'b1; y_tdata = d; y_tlast = last;
        check("y_tready_push", 32'(y_tready), 32'd1);
        tick();
        y_tvalid = 1'b0; y_tlast = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_xvalid", 32'(x_tvalid), 32'd0);
        check("rst_xdata", x_tdata, 32'd0);
        check("rst_xlast", 32'(x_tlast), 32'd0);
        check("rst_yready", 32'(y_tready), 32'd1);
        rst = 1'b1;
        tick();
        wb_rd("rst_status", A_STATUS, 32'h0000_0002);
        wb_rd("rst_cnt", A_CNT, 32'h0);

        // Outside the window: never acknowledged, no side effect
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0008; wdat = 32'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("oow_noack", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();

        // Register table: LEN, reserved offsets, four X pushes with TX stalled
        vecs.push_back('{1'b1, A_LEN,           32'd3,      32'd0,          "wr_len"});
        vecs.push_back('{1'b0, A_LEN,           32'd0,      32'd3,          "rd_len"});
        vecs.push_back('{1'b0, A_CTRL,          32'd0,      32'd0,          "rd_ctrl"});
        vecs.push_back('{1'b1, 32'h3000_0098,   32'hDEAD,   32'd0,          "wr_rsv18"});
        vecs.push_back('{1'b0, 32'h3000_0098,   32'd0,      32'd0,          "rd_rsv18"});
        vecs.push_back('{1'b0, 32'h3000_009C,   32'd0,      32'd0,          "rd_rsv1c"});
        vecs.push_back('{1'b1, A_X,             32'd1,      32'd0,          "wr_x1"});
        vecs.push_back('{1'b1, A_X,             32'd2,      32'd0,          "wr_x2"});
        vecs.push_back('{1'b1, A_X,             32'd3,      32'd0,          "wr_x3"});
        vecs.push_back('{1'b1, A_X,             32'd4,      32'd0,          "wr_x4"});
        vecs.push_back('{1'b0, A_STATUS,        32'd0,      32'h0000_0402,  "st_tx4"});
        vecs.push_back('{1'b0, A_CNT,           32'd0,      32'd0,          "cnt_pre"});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wb_wr(vecs[i].name, vecs[i].a, vecs[i].d);
            else            wb_rd(vecs[i].name, vecs[i].a, vecs[i].exp);
        end

        // Drain: 1,2,3,4 with tlast only on 3
        x_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(x_tvalid), 32'd1);
            check("drain_data", x_tdata, 32'(i + 1));
            check("drain_last", 32'(x_tlast), (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        check("drain_empty", 32'(x_tvalid), 32'd0);
        x_tready = 1'b0;
        wb_rd("cnt_sent4", A_CNT, 32'h0000_0004);
        wb_rd("st_drained", A_STATUS, 32'h0000_0002);

        // Nine writes into a stalled TX FIFO of depth 8
        wb_wr("clr1", A_CTRL, 32'd1);
        for (int i = 0; i < 8; i++) wb_wr("fill", A_X, 32'(100 + i));
        wb_rd("st_full", A_STATUS, 32'h0000_0803);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_X; wdat = 32'd108;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("x9_held", 32'(ack), 32'd0);
        end
        x_tready = 1'b1;
        check("x9_head", x_tdata, 32'd100);
        tick();
        x_tready = 1'b0;
        check("x9_still_held", 32'(ack), 32'd0);
        tick();
        check("x9_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_rd("st_full2", A_STATUS, 32'h0000_0803);
        wb_rd("cnt_sent1", A_CNT, 32'h0000_0001);
        wb_wr("clr2", A_CTRL, 32'd1);
        check("clr2_xvalid", 32'(x_tvalid), 32'd0);

        // RX stream 10,20,30 with tlast on 30
        y_push(32'd10, 1'b0);
        y_push(32'd20, 1'b0);
        y_push(32'd30, 1'b1);
        wb_rd("st_rx3", A_STATUS, 32'h0003_0004);
        wb_rd("y10", A_Y, 32'd10);
        wb_rd("y20", A_Y, 32'd20);
        wb_rd("y30", A_Y, 32'd30);
        wb_rd("st_rxdone", A_STATUS, 32'h0000_0006);
        wb_rd("cnt_recv3", A_CNT, 32'h0003_0000);

        // Y read held off on empty RX until a sample arrives
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_Y;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("y_held", 32'(ack), 32'd0);
        end
        y_tvalid = 1'b1; y_tdata = 32'h55;
        tick();
        y_tvalid = 1'b0;
        check("y_held_push", 32'(ack), 32'd0);
        tick();
        check("y_late_ack", 32'(ack), 32'd1);
        check("y_late_dat", dat_o, 32'h55);
        cyc = 1'b0; stb = 1'b0;

        // CLEAR with both FIFOs partly full and simultaneous handshakes
        wb_wr("px7", A_X, 32'd7);
        wb_wr("px8", A_X, 32'd8);
        y_push(32'h11, 1'b0);
        y_push(32'h22, 1'b1);
        wb_rd("st_preclr", A_STATUS, 32'h0002_0204);
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; wdat = 32'd1;
        x_tready = 1'b1; y_tvalid = 1'b1; y_tdata = 32'h33;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        x_tready = 1'b0; y_tvalid = 1'b0;
        check("clr_ack", 32'(ack), 32'd1);
        check("clr_xvalid", 32'(x_tvalid), 32'd0);
        wb_rd("st_postclr", A_STATUS, 32'h0000_0002);
        wb_rd("cnt_postclr", A_CNT, 32'h0);
        wb_rd("len_kept", A_LEN, 32'd3);

        // Reset mid-stream
        wb_wr("rx_a", A_X, 32'hA);
        y_push(32'hB, 1'b0);
        x_tready = 1'b1; y_tvalid = 1'b1; y_tdata = 32'hC;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_xvalid", 32'(x_tvalid), 32'd0);
        check("mrst_xdata", x_tdata, 32'd0);
        check("mrst_xlast", 32'(x_tlast), 32'd0);
        check("mrst_yready", 32'(y_tready), 32'd1);
        check("mrst_ack", 32'(ack), 32'd0);
        x_tready = 1'b0; y_tvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        wb_rd("mrst_len", A_LEN, 32'd0);
        wb_rd("mrst_status", A_STATUS, 32'h0000_0002);
        wb_rd("mrst_cnt", A_CNT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_stream_bridge.md
# fir_stream_bridge

Wishbone-to-AXI-Stream bridge that lets the CPU drive the FIR engine sample-by-sample. It sits between the Wishbone slave decode and the FIR's stream ports. A TX FIFO fed by Wishbone writes drives the FIR input stream (X), and an RX FIFO filled from the FIR output stream (Y) is drained by Wishbone reads. The bridge generates tlast from a programmed frame length and tracks frame completion and sample counts.

## Interface
- DEPTH, 8, entries per FIFO (power of two, ≥2); CW = clog2(DEPTH)+1 is the count width
- BASE, 32'h3000_0080, window base; 32-byte window, hit = adr[31:5]==BASE[31:5]
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone request
- wbs_sel_i  in  4  ignored (full-word only)
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle registered acknowledge
- wbs_dat_o  out  32  read data; valid only with ack, else 0
- x_tvalid  out  1, x_tready  in  1, x_tdata  out  32, x_tlast  out  1  stream to FIR input
- y_tvalid  in  1, y_tready  out  1, y_tdata  in  32, y_tlast  in  1  stream from FIR output

## Operation
- Registers (offset from BASE):
  - 0x00 CTRL W: bit0 CLEAR flushes both FIFOs, counters and DONE. Reads return 0.
  - 0x04 LEN R/W, [15:0]: frame length. LEN=0 never asserts tlast.
  - 0x08 X W: push to TX FIFO.
  - 0x0C Y R: pop from RX FIFO.
  - 0x10 STATUS R: [0] tx_full, [1] rx_empty, [2] DONE, [15:8] tx_count, [23:16] rx_count, zero-extended.
  - 0x14 CNT R: [15:0] samples sent, [31:16] samples received. Both wrap mod 2^16.
- Offsets 0x18–0x1C: ack, read 0, writes ignored. Outside the window: no ack, no side effect.
- A request is accepted when cyc&stb&hit&~ack. X write while tx_full and Y read while rx_empty hold off: no ack until room or data exists, then the access executes.
- TX push stores {tlast,data}. tlast=1 when LEN≠0 and frame index==LEN-1. The frame index increments per push and wraps to 0 after a tlast entry.
- Outputs:
  - x_tvalid = ~tx_empty; x_tdata/x_tlast come from the TX head.
  - y_tready = ~rx_full.
- Handshake: on x_tvalid&x_tready, pop TX and increment sent. On y_tvalid&y_tready, push {y_tdata} to RX, increment received; if y_tlast, set DONE (sticky).
- Push and pop on the same FIFO in the same cycle both occur; the count is unchanged.
- CLEAR takes priority over a same-cycle stream handshake (the handshake is dropped). LEN is retained.
- A held-off X/Y request persists across CLEAR and completes once its condition is met.

## Timing
- Reset: ack=0, dat_o=0, x_tvalid=0, x_tlast=0, x_tdata=0, y_tready=1. FIFOs empty, counters 0, LEN=0, DONE=0.
- Reset asserted mid-transfer aborts immediately. Any pending Wishbone request is re-evaluated after release.
- Wishbone access latency is 1 cycle: accept in cycle n, ack and dat_o in n+1.
- X write: data is visible on x_tdata at n+1 at the earliest (registered FIFO state).
- Y read: pops the current head at acceptance and returns it with the ack.
- Stream in: y_tdata accepted at cycle m is readable via Y at m+1 at the earliest.
- Stream out: the FIFO is never over- or under-run. x_tvalid never deasserts without a handshake, except on CLEAR or reset.

## Structure
- Package fir_bridge_pkg: register offsets, STATUS bit positions, default BASE.
- Sub-module sync_fifo (DATA_W, DEPTH), instantiated twice:
  - TX, 33 bits wide;
  - RX, 32 bits wide.
  - Ports: push, pop, din, dout, full, empty, count, clear.
  - Read and write pointers, wrap-around by pointer MSB.

## Test plan
- Reset value check: STATUS reads 0x0000_0002, y_tready=1, x_tvalid=0.
- LEN=3, write X=1,2,3,4 with x_tready=1: x_tdata sequence 1,2,3,4, x_tlast only on 3; CNT[15:0]=4.
- x_tready=0, write 9 words with DEPTH=8: the 9th write's ack is withheld until x_tready pulses once; tx_count peaks at 8.
- y_tvalid stream 10,20,30 with y_tlast on 30, then read Y three times: returns 10,20,30; STATUS DONE=1, rx_empty=1; CNT[31:16]=3.
- Read Y with RX empty, y_tvalid=1 with 0x55 three cycles later: ack arrives with dat_o=0x55, one cycle after the push.
- CLEAR while both FIFOs are partly full, with a simultaneous handshake: counts go to 0, DONE=0, LEN is unchanged; reset asserted mid-stream returns all outputs to reset values.
